// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 4;

    function automatic int digit_count(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/digit_adder.sv
// One DIGIT-wide slice of the serial adder: a + b + cin -> {cout, sum}.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/serial_adder.sv
// Digit-serial unsigned adder: WIDTH/DIGIT RUN cycles, one DONE cycle, z = {carry, sum}.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   z
);

    localparam int             NDIG = digit_count(WIDTH, DIGIT);
    localparam int             CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NDIG - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [DIGIT-1:0] dsum;
    logic             dcout;
    logic             accept, last;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a    (a_sh[DIGIT-1:0]),
        .b    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .sum  (dsum),
        .cout (dcout)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == LAST);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // New digit enters at the top so the full sum lands LSB-aligned after the last digit.
    assign sum_next = (sum_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            z      <= '0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            sum_sh <= sum_next;
            carry  <= dcout;
            cnt    <= last ? '0 : cnt + CW'(1);
            // z is the only architecturally visible result; it moves once per addition.
            if (last) z <= {dcout, sum_next};
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: table vectors, directed corner sequences and random sums at DIGIT 4, 1, 8.
module tb_serial_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] z;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       st;
    logic [2:0][31:0] av, bv;
    logic [2:0]       bz, dn;
    logic [2:0][32:0] zv;

    int          checks = 0;
    int          errors = 0;
    int          nd[3] = '{8, 32, 4};
    logic [32:0] zprev[3];
    vec_t        tbl[6];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(32), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(av[0]), .b(bv[0]),
        .busy(bz[0]), .done(dn[0]), .z(zv[0]));
    serial_adder #(.WIDTH(32), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(av[1]), .b(bv[1]),
        .busy(bz[1]), .done(dn[1]), .z(zv[1]));
    serial_adder #(.WIDTH(32), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .a(av[2]), .b(bv[2]),
        .busy(bz[2]), .done(dn[2]), .z(zv[2]));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Full addition on instance k; operands are disturbed during RUN.
    task automatic run_add(input int k, input logic [31:0] x, input logic [31:0] y,
                           input bit scramble, input string nm);
        logic [32:0] exp;
        int          lat, nb;
        bit          zmoved;
        exp = {1'b0, x} + {1'b0, y};
        av[k] = x; bv[k] = y; st[k] = 1'b1;
        step();
        st[k] = 1'b0;
        av[k] = scramble ? 32'($urandom) : 32'h0;
        bv[k] = scramble ? 32'($urandom) : 32'h0;
        lat = 1; nb = 0; zmoved = 0;
        while (!dn[k] && lat < 100) begin
            if (bz[k]) nb++;
            if (zv[k] !== zprev[k]) zmoved = 1;
            step();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(nd[k] + 1));
        chk({nm, " busy_cycles"}, 64'(nb), 64'(nd[k]));
        chk({nm, " z_held_in_run"}, 64'(zmoved), 64'(0));
        chk({nm, " z"}, 64'(zv[k]), 64'(exp));
        chk({nm, " busy_in_done"}, 64'(bz[k]), 64'(0));
        zprev[k] = exp;
        step();
        chk({nm, " done_single"}, 64'(dn[k]), 64'(0));
        chk({nm, " z_hold_idle"}, 64'(zv[k]), 64'(exp));
    endtask

    initial begin
        int lat, ndone;
        logic [31:0] ra, rb;

        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
        tbl[1] = '{32'h1234_5678, 32'h8765_4321, 33'h0_9999_9999};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 33'h0_0000_0000};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
        tbl[4] = '{32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF};
        tbl[5] = '{32'hDEAD_BEEF, 32'h2152_4111, 33'h1_0000_0000};

        rst_n = 1'b0; st = '0; av = '0; bv = '0;
        for (int k = 0; k < 3; k++) zprev[k] = '0;
        step(); step();
        for (int k = 0; k < 3; k++) begin
            chk("reset busy", 64'(bz[k]), 64'(0));
            chk("reset done", 64'(dn[k]), 64'(0));
            chk("reset z", 64'(zv[k]), 64'(0));
        end

        // Start in the very first cycle after reset release.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_add(0, tbl[i].a, tbl[i].b, 1'b0, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d z_vs_table", i), 64'(zprev[0]), 64'(tbl[i].z));
        end

        // A start arriving mid-RUN is ignored.
        av[0] = 32'd5; bv[0] = 32'd7; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        step(); step();
        av[0] = 32'd1; bv[0] = 32'd1; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        lat = 4; ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (dn[0]) begin
                ndone++;
                chk("midstart latency", 64'(lat), 64'(9));
                chk("midstart z", 64'(zv[0]), 64'(12));
            end
            step();
            lat++;
        end
        chk("midstart done_count", 64'(ndone), 64'(1));
        chk("midstart z_after", 64'(zv[0]), 64'(12));

        // Back-to-back: start held high during DONE.
        av[0] = 32'd5; bv[0] = 32'd7; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        lat = 1;
        while (!dn[0] && lat < 100) begin step(); lat++; end
        chk("b2b first_done", 64'(dn[0]), 64'(1));
        av[0] = 32'h8000_0000; bv[0] = 32'h8000_0000; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        chk("b2b busy_after_done", 64'(bz[0]), 64'(1));
        chk("b2b z_held", 64'(zv[0]), 64'(12));
        lat = 1;
        while (!dn[0] && lat < 100) begin step(); lat++; end
        chk("b2b latency", 64'(lat), 64'(9));
        chk("b2b z", 64'(zv[0]), 64'h1_0000_0000);
        step();
        zprev[0] = 33'h1_0000_0000;

        // Reset at RUN cycle 4 aborts without a done pulse.
        av[0] = 32'h1234_5678; bv[0] = 32'h8765_4321; st[0] = 1'b1;
        step();
        st[0] = 1'b0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(bz[0]), 64'(0));
        chk("abort done", 64'(dn[0]), 64'(0));
        chk("abort z", 64'(zv[0]), 64'(0));
        for (int k = 0; k < 3; k++) zprev[k] = '0;
        step();
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            if (dn[0] || bz[0]) ndone++;
            step();
        end
        chk("abort no_done", 64'(ndone), 64'(0));
        run_add(0, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b1, "post_abort");

        // Random operands against plain 33-bit addition at each digit size.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
                if (i % 50 == 0) ra = 32'hFFFF_FFFF;
                run_add(k, ra, rb, 1'b1, $sformatf("rnd_d%0d_%0d", k, i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32: operand width in bits.
REQ-002 The block SHALL take parameter DIGIT, default 4: bits added per clock; WIDTH mod DIGIT SHALL be 0.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  request to begin an addition of a and b.
REQ-006 The block SHALL have port a  input  WIDTH  first operand, sampled only on an accepted start.
REQ-007 The block SHALL have port b  input  WIDTH  second operand, sampled only on an accepted start.
REQ-008 The block SHALL have port busy  output  1  high while an addition is in progress.
REQ-009 The block SHALL have port done  output  1  single-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port z  output  WIDTH+1  sum; bit WIDTH is carry-out, matching the cla/rca result format.

Function
REQ-011 FSM states SHALL be IDLE, RUN and DONE.
REQ-012 start SHALL be accepted only in IDLE or DONE; an accepted start captures a and b into shift registers, clears the carry and the digit counter, and enters RUN.
REQ-013 start in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-014 Each RUN cycle SHALL add the low DIGIT bits of both operand shift registers plus the carry register.
  - DIGIT sum bits shift into the result register from the top.
  - Carry-out is registered.
  - Operand registers shift right by DIGIT.
REQ-015 RUN SHALL last exactly WIDTH/DIGIT cycles (8 at defaults); the counter wraps from WIDTH/DIGIT-1 to the exit transition, never beyond.
REQ-016 After the last RUN cycle the FSM SHALL enter DONE for exactly one cycle; done=1 only in DONE.
  - z = {final carry, WIDTH sum bits}.
  - DONE goes to IDLE, or to RUN if start is high in DONE.
REQ-017 Latency from accepted start edge to done high SHALL be WIDTH/DIGIT+1 cycles (9 at defaults).
REQ-018 busy SHALL be 1 exactly in RUN.
REQ-019 z SHALL update only on the DONE transition and hold its value through IDLE and any following RUN until the next DONE.
  - Intermediate shift contents never appear on z.
REQ-020 Arithmetic SHALL be unsigned modulo 2^(WIDTH+1).
  - a+b with no carry-in.
  - z SHALL equal the cla/rca results for identical operands.
REQ-021 Operand inputs changing during RUN SHALL NOT affect the result.

Reset
REQ-022 rst_n low SHALL asynchronously force:
  - state to IDLE;
  - busy=0, done=0, z=0;
  - carry, counter and operand registers to 0.
REQ-023 Reset asserted mid-RUN SHALL abort the addition with no done pulse; the first start after rst_n rises SHALL behave as from power-up.
REQ-024 start high in the first cycle after reset release SHALL be accepted.

Structure
REQ-025 A shared package serial_adder_pkg SHALL hold:
  - the state enum typedef (IDLE, RUN, DONE);
  - default WIDTH and DIGIT constants;
  - a function returning the digit count WIDTH/DIGIT.
REQ-026 The block SHALL instantiate one combinational sub-module digit_adder (DIGIT-bit a, b, carry-in -> DIGIT-bit sum, carry-out); all registers and the FSM reside in serial_adder.
REQ-027 Counter width SHALL be $clog2(WIDTH/DIGIT), minimum 1 bit.

Verification
REQ-028 Bench SHALL drive a=0xFFFFFFFF, b=0x00000001, 1-cycle start -> busy high 8 cycles, done pulses at cycle 9, z=0x1_00000000.
REQ-029 Bench SHALL drive a=0x12345678, b=0x87654321, then change a/b to 0 during RUN -> z=0x0_99999999.
REQ-030 Bench SHALL start a=5, b=7, then pulse start with a=1, b=1 at RUN cycle 3 -> single done, z=12; second request ignored.
REQ-031 Bench SHALL hold start high in DONE with new a=0x80000000, b=0x80000000 -> back-to-back, next done 9 cycles later, z=0x1_00000000.
REQ-032 Bench SHALL assert rst_n low at RUN cycle 4 -> busy=0, done never pulses, z=0; a new start afterwards yields the correct sum.
REQ-033 Bench SHALL run 1000 random operand pairs for DIGIT in {1,4,8} -> z equals a+b (33-bit) and latency is WIDTH/DIGIT+1 every time.
